// File: rtl/reg_bank16.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank16
// Brief    : 16x32 register bank with byte-enable writes, one-entry-per-cycle
//            clear sweep and registered read select. Define REG_BANK_PARITY_EN
//            for per-entry even parity with fault injection.
// Revision : 1.0
// ============================================================================
module reg_bank16 #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000,
  parameter logic [15:0] WR_MASK   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        clr_req,
  output logic        busy,
  input  logic [3:0]  rd_sel_in,
  output logic [3:0]  rd_sel_q,
  output logic [31:0] bank_out [15:0],
`ifdef REG_BANK_PARITY_EN
  input  logic        par_inj,
  output logic        par_err,
`endif
  output logic [15:0] dirty
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_CLEAR = 1'b1;

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_rd_sel;
  logic       w_wr_acc;

  assign wr_ready = (r_state == c_IDLE);
  assign busy     = (r_state == c_CLEAR);
  assign w_wr_acc = wr_valid && wr_ready;
  assign rd_sel_q = r_rd_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (clr_req) begin
            r_state <= c_CLEAR;
            r_cnt   <= 4'd0;
          end
        end
        c_CLEAR: begin
          // counter wraps back to 0 as the last entry is cleared
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_sel <= 4'd0;
    end else begin
      r_rd_sel <= rd_sel_in;
    end
  end

`ifdef REG_BANK_PARITY_EN
  logic [15:0] w_par;
  logic        r_par_err;

  assign par_err = r_par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= (^bank_out[r_rd_sel]) ^ w_par[r_rd_sel];
    end
  end
`endif

  for (genvar i = 0; i < 16; i++) begin : g_entry
    logic [31:0] r_word;
    logic        r_dirty;
    logic [31:0] w_merged;
    logic        w_wr_hit;
    logic        w_clr_hit;

    // read-only entries still complete the handshake but never change
    assign w_wr_hit  = w_wr_acc && (wr_addr == 4'(i)) && WR_MASK[i];
    assign w_clr_hit = (r_state == c_CLEAR) && (r_cnt == 4'(i));

    for (genvar k = 0; k < 4; k++) begin : g_byte
      assign w_merged[8*k +: 8] = wr_be[k] ? wr_data[8*k +: 8] : r_word[8*k +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_word  <= RESET_VAL;
        r_dirty <= 1'b0;
      end else if (w_clr_hit) begin
        r_word  <= RESET_VAL;
        r_dirty <= 1'b0;
      end else if (w_wr_hit) begin
        r_word <= w_merged;
        if (wr_be != 4'b0000) begin
          r_dirty <= 1'b1;
        end
      end
    end

    assign bank_out[i] = r_word;
    assign dirty[i]    = r_dirty;

`ifdef REG_BANK_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_par <= ^RESET_VAL;
      end else if (w_clr_hit) begin
        r_par <= ^RESET_VAL;
      end else if (w_wr_hit) begin
        r_par <= (^w_merged) ^ par_inj;
      end
    end

    assign w_par[i] = r_par;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank16.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank16
// Brief    : Directed scoreboard bench for reg_bank16 (WR_MASK = 16'hFFFE).
// Revision : 1.0
// ============================================================================
module tb_reg_bank16;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [15:0] MASK = 16'hFFFE;

  localparam int K_BANK  = 0;
  localparam int K_DIRTY = 1;
  localparam int K_RDY   = 2;
  localparam int K_BUSY  = 3;
  localparam int K_SEL   = 4;
  localparam int K_PERR  = 5;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clr_req;
  logic        busy;
  logic [3:0]  rd_sel_in;
  logic [3:0]  rd_sel_q;
  logic [31:0] bank_out [15:0];
  logic [15:0] dirty;
`ifdef REG_BANK_PARITY_EN
  logic        par_inj;
  logic        par_err;
`endif

  reg_bank16 #(.RESET_VAL(RV), .WR_MASK(MASK)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .clr_req   (clr_req),
    .busy      (busy),
    .rd_sel_in (rd_sel_in),
    .rd_sel_q  (rd_sel_q),
    .bank_out  (bank_out),
`ifdef REG_BANK_PARITY_EN
    .par_inj   (par_inj),
    .par_err   (par_err),
`endif
    .dirty     (dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_bank [16];
  logic [15:0] m_dirty;
  logic [15:0] m_mask;
  int          checks;
  int          failures;

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    logic [3:0] a;
    a = idx[3:0];
    case (kind)
      K_BANK:  return bank_out[a];
      K_DIRTY: return {16'h0000, dirty};
      K_RDY:   return {31'd0, wr_ready};
      K_BUSY:  return {31'd0, busy};
      K_SEL:   return {28'd0, rd_sel_q};
`ifdef REG_BANK_PARITY_EN
      K_PERR:  return {31'd0, par_err};
`endif
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.kind, e.idx);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s[%0d] observed=%h expected=%h", e.tag, e.idx, o, e.val);
      end
    end
  endtask

  task automatic push_all(input string tag);
    for (int i = 0; i < 16; i++) push(tag, K_BANK, i, m_bank[i]);
    push({tag, "_dirty"}, K_DIRTY, 0, {16'h0000, m_dirty});
  endtask

  function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    if (m_mask[a]) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) m_bank[a][8*k +: 8] = d[8*k +: 8];
      end
      if (be != 4'b0000) m_dirty[a] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_bank[i] = RV;
    m_dirty = 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_mask    = MASK;
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = 4'd0;
    wr_data   = 32'd0;
    wr_be     = 4'd0;
    clr_req   = 1'b0;
    rd_sel_in = 4'd0;
`ifdef REG_BANK_PARITY_EN
    par_inj   = 1'b0;
`endif
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_all("reset_bank");
    push("reset_rdy", K_RDY, 0, 32'd1);
    push("reset_busy", K_BUSY, 0, 32'd0);
    push("reset_sel", K_SEL, 0, 32'd0);
`ifdef REG_BANK_PARITY_EN
    push("reset_perr", K_PERR, 0, 32'd0);
`endif
    drain();

    // Byte-enable write, then registered select
    drive_wr(4'd5, 32'hDEAD_BEEF, 4'b0101);
    push("wr5_rdy", K_RDY, 0, 32'd1);
    drain();
    tick();
    wr_valid = 1'b0;
    model_write(5, 32'hDEAD_BEEF, 4'b0101);
    push("wr5_bank", K_BANK, 5, 32'h00AD_00EF);
    push("wr5_dirty", K_DIRTY, 0, 32'h0000_0020);
    drain();
    rd_sel_in = 4'd5;
    push("sel_before", K_SEL, 0, 32'd0);
    drain();
    tick();
    push("sel5", K_SEL, 0, 32'd5);
    drain();

    // Read-only entry 0 and a zero-byte-enable write to entry 6
    drive_wr(4'd0, 32'h1234_5678, 4'hF);
    push("ro_rdy", K_RDY, 0, 32'd1);
    drain();
    tick();
    model_write(0, 32'h1234_5678, 4'hF);
    drive_wr(4'd6, 32'h7777_7777, 4'h0);
    push("ro_bank", K_BANK, 0, RV);
    push("ro_dirty", K_DIRTY, 0, 32'h0000_0020);
    drain();
    tick();
    model_write(6, 32'h7777_7777, 4'h0);
    wr_valid = 1'b0;
    push("be0_bank", K_BANK, 6, RV);
    push("be0_dirty", K_DIRTY, 0, 32'h0000_0020);
    drain();

    // Fill every entry, then a full clear sweep
    for (int a = 0; a < 16; a++) begin
      drive_wr(4'(a), 32'hA5A5_A5A5, 4'hF);
      tick();
      model_write(a, 32'hA5A5_A5A5, 4'hF);
    end
    wr_valid = 1'b0;
    push_all("fill");
    drain();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push("sweep_busy", K_BUSY, i, 32'd1);
      push("sweep_rdy", K_RDY, i, 32'd0);
      push("sweep_pre", K_BANK, i, m_bank[i]);
      drain();
      tick();
      m_bank[i]  = RV;
      m_dirty[i] = 1'b0;
      push("sweep_clr", K_BANK, i, RV);
      push("sweep_dirty", K_DIRTY, i, {16'h0000, m_dirty});
      drain();
    end
    push("sweep_end_busy", K_BUSY, 0, 32'd0);
    push("sweep_end_rdy", K_RDY, 0, 32'd1);
    push("sweep_end_dirty", K_DIRTY, 0, 32'd0);
    drain();

    // Write and clear on the same edge; stalled write during the sweep
    drive_wr(4'd3, 32'hFFFF_FFFF, 4'hF);
    clr_req = 1'b1;
    push("wc_rdy", K_RDY, 0, 32'd1);
    drain();
    tick();
    model_write(3, 32'hFFFF_FFFF, 4'hF);
    clr_req = 1'b0;
    push("wc_bank3", K_BANK, 3, 32'hFFFF_FFFF);
    push("wc_busy", K_BUSY, 0, 32'd1);
    drain();
    drive_wr(4'd9, 32'h0BAD_CAFE, 4'hF);
    for (int i = 0; i < 16; i++) begin
      rd_sel_in = 4'(i);
      push("stall_rdy", K_RDY, i, 32'd0);
      push("stall_bank9", K_BANK, 9, m_bank[9]);
      drain();
      tick();
      m_bank[i]  = RV;
      m_dirty[i] = 1'b0;
      push("stall_sel", K_SEL, i, 32'(i));
      push("stall_bank3", K_BANK, 3, m_bank[3]);
      drain();
    end
    push("stall_end_rdy", K_RDY, 0, 32'd1);
    push("stall_end_busy", K_BUSY, 0, 32'd0);
    drain();
    tick();
    model_write(9, 32'h0BAD_CAFE, 4'hF);
    wr_valid = 1'b0;
    push("stall_acc_bank", K_BANK, 9, 32'h0BAD_CAFE);
    push("stall_acc_dirty", K_DIRTY, 0, {16'h0000, m_dirty});
    drain();

    // Reset in the middle of a sweep
    drive_wr(4'd12, 32'h5555_AAAA, 4'hF);
    tick();
    model_write(12, 32'h5555_AAAA, 4'hF);
    wr_valid  = 1'b0;
    rd_sel_in = 4'd11;
    clr_req   = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    push_all("midrst");
    push("midrst_busy", K_BUSY, 0, 32'd0);
    push("midrst_rdy", K_RDY, 0, 32'd1);
    push("midrst_sel", K_SEL, 0, 32'd0);
    drain();
    #1;
    rst = 1'b0;
    tick();
    push("postrst_busy", K_BUSY, 0, 32'd0);
    push("postrst_bank12", K_BANK, 12, RV);
    push("postrst_sel", K_SEL, 0, 32'd11);
    drain();

`ifdef REG_BANK_PARITY_EN
    // Parity fault injection on entry 2, clean parity on entry 5
    drive_wr(4'd2, 32'h0000_0001, 4'hF);
    par_inj = 1'b1;
    tick();
    wr_valid  = 1'b0;
    par_inj   = 1'b0;
    rd_sel_in = 4'd2;
    tick();
    push("par_sel", K_SEL, 0, 32'd2);
    drain();
    tick();
    push("par_err_inj", K_PERR, 0, 32'd1);
    drain();
    rd_sel_in = 4'd5;
    tick();
    tick();
    push("par_err_clean", K_PERR, 0, 32'd0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
